// File: rtl/vit_pkg.sv
// vit_pkg: shared constants and types for the Viterbi traceback controller
package vit_pkg;
  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, TRACE} tb_state_t;
  typedef logic bank_t;
endpackage

// File: rtl/tbu_ctrl_if.sv
// tbu_ctrl_if: ACS handshake plus survivor-RAM and tbu control bundle
interface tbu_ctrl_if #(parameter int AW = vit_pkg::AW);
  logic acs_valid, acs_ready, mem_wr_en, wr_bank, selection, enable, tb_start, tb_done, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  modport master(input acs_valid, output acs_ready, mem_wr_en, wr_bank, wr_addr, rd_addr, selection, enable, tb_start, tb_done, busy);
  modport slave(output acs_valid, input acs_ready, mem_wr_en, wr_bank, wr_addr, rd_addr, selection, enable, tb_start, tb_done, busy);
endinterface

// File: rtl/tbu_wr_ptr.sv
// tbu_wr_ptr: write pointer/bank counter with fill and (TBU_CTRL_FLUSH_EN) flush detection
module tbu_wr_ptr import vit_pkg::*; #(
  parameter int DEPTH = vit_pkg::DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
`ifdef TBU_CTRL_FLUSH_EN
  input  logic          flush,
  output logic [AW:0]   fill_len,
`endif
  output logic [AW-1:0] wr_ptr,
  output bank_t         wr_bank,
  output logic          fill
);
  logic last;
  assign last = accept && wr_ptr == AW'(DEPTH - 1);
`ifdef TBU_CTRL_FLUSH_EN
  // word count including this cycle's accept; equals DEPTH on a normal fill
  assign fill_len = {1'b0, wr_ptr} + (AW + 1)'(accept);
  assign fill = last || (flush && fill_len != '0);
`else
  assign fill = last;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
    end else if (fill) begin
      wr_ptr  <= '0;
      wr_bank <= ~wr_bank;
    end else if (accept) wr_ptr <= wr_ptr + 1'b1;
endmodule

// File: rtl/tbu_ctrl.sv
// tbu_ctrl: ping-pong survivor bank sequencer and traceback sweep FSM; TBU_CTRL_FLUSH_EN adds flush
module tbu_ctrl import vit_pkg::*; #(
  parameter int DEPTH = vit_pkg::DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
`ifdef TBU_CTRL_FLUSH_EN
  input logic flush,
`endif
  tbu_ctrl_if.master bus
);
  logic [1:0] bank_full;
  bank_t tb_bank;
  tb_state_t state, state_n;
  logic [AW-1:0] rd_n, first;
  logic fill, sel_n, en_n, start_n, done_n, clr;
  assign bus.acs_ready = !bank_full[bus.wr_bank];
  assign bus.mem_wr_en = bus.acs_valid & bus.acs_ready;
  assign bus.busy = state == TRACE;
`ifdef TBU_CTRL_FLUSH_EN
  logic [AW:0] len [2];
  logic [AW:0] fill_len;
  tbu_wr_ptr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .rst(rst), .accept(bus.mem_wr_en), .flush(flush), .fill_len(fill_len),
    .wr_ptr(bus.wr_addr), .wr_bank(bus.wr_bank), .fill(fill));
  always_ff @(posedge clk or posedge rst)
    if (rst) len <= '{(AW + 1)'(DEPTH), (AW + 1)'(DEPTH)};
    else if (fill) len[bus.wr_bank] <= fill_len;
  assign first = AW'(len[tb_bank] - 1'b1);
`else
  tbu_wr_ptr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .rst(rst), .accept(bus.mem_wr_en),
    .wr_ptr(bus.wr_addr), .wr_bank(bus.wr_bank), .fill(fill));
  assign first = AW'(DEPTH - 1);
`endif
  always_comb begin
    state_n = state;
    rd_n = bus.rd_addr;
    sel_n = bus.selection;
    en_n = bus.enable;
    start_n = 1'b0;
    done_n = 1'b0;
    clr = 1'b0;
    if (state == IDLE && bank_full[tb_bank]) begin
      state_n = TRACE;
      rd_n = first;
      sel_n = tb_bank;
      en_n = 1'b1;
      start_n = 1'b1;
    end else if (state == TRACE && bus.rd_addr != '0) rd_n = bus.rd_addr - 1'b1;
    else if (state == TRACE) begin
      state_n = IDLE;
      en_n = 1'b0;
      done_n = 1'b1;
      clr = 1'b1;
    end
  end
  // a bank's full flag is set by the writer and cleared by the sweep; the two never target the same bank at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bank_full <= '0;
      tb_bank <= 1'b0;
      bus.rd_addr <= '0;
      bus.selection <= 1'b0;
      bus.enable <= 1'b0;
      bus.tb_start <= 1'b0;
      bus.tb_done <= 1'b0;
    end else begin
      state <= state_n;
      bank_full <= (bank_full | ({1'b0, fill} << bus.wr_bank)) & ~({1'b0, clr} << tb_bank);
      tb_bank <= tb_bank ^ clr;
      bus.rd_addr <= rd_n;
      bus.selection <= sel_n;
      bus.enable <= en_n;
      bus.tb_start <= start_n;
      bus.tb_done <= done_n;
    end
endmodule
